// File: rtl/mult_operand_sequencer.sv
// Operand sequencer for a shift-add multiplier: accepts an operand pair, pulses start,
// waits for done (with timeout) and holds the product for downstream. Optional macro: ZERO_BYPASS_EN.
module mult_operand_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        mult_start,
  output logic [15:0] mult_multiplicand,
  output logic [15:0] mult_multiplier,
  input  logic        mult_done,
  input  logic [31:0] mult_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mult_start_q, mult_start_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_product_q, out_product_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        transfer_s;

  assign transfer_s = in_valid & in_ready_q;

  // Next-state and datapath; all outputs are derived from the next state so they stay registered
  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    out_product_d = out_product_q;
    timeout_err_d = timeout_err_q;
    ops_done_d    = ops_done_q;
    tcnt_d        = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer_s) begin
          mcand_d  = in_a;
          mplier_d = in_b;
`ifdef ZERO_BYPASS_EN
          if ((in_a == 16'h0000) || (in_b == 16'h0000)) begin
            out_product_d = 32'h0000_0000;
            state_d       = ST_OUT;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tcnt_d  = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the final timeout cycle still counts as success
        if (mult_done) begin
          out_product_d = mult_product;
          state_d       = ST_OUT;
        end else if (tcnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          out_product_d = 32'hFFFF_FFFF;
          state_d       = ST_OUT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d   = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    mult_start_d = (state_d == ST_ISSUE);
    out_valid_d  = (state_d == ST_OUT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b1;
      mult_start_q  <= 1'b0;
      mcand_q       <= 16'h0000;
      mplier_q      <= 16'h0000;
      out_valid_q   <= 1'b0;
      out_product_q <= 32'h0000_0000;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ops_done_q    <= 16'h0000;
      tcnt_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      mult_start_q  <= mult_start_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      ops_done_q    <= ops_done_d;
      tcnt_q        <= tcnt_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign mult_start        = mult_start_q;
  assign mult_multiplicand = mcand_q;
  assign mult_multiplier   = mplier_q;
  assign out_valid         = out_valid_q;
  assign out_product       = out_product_q;
  assign busy              = busy_q;
  assign timeout_err       = timeout_err_q;
  assign ops_done          = ops_done_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Self-checking bench for mult_operand_sequencer: directed and random operand pairs
// against a transaction-level model of latency, products, timeout and op counting.
module tb_mult_operand_sequencer;

  localparam int TO = 64;
`ifdef ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk, reset, in_valid, in_ready, mult_start, mult_done;
  logic        out_valid, out_ready, busy, timeout_err;
  logic [15:0] in_a, in_b, mult_multiplicand, mult_multiplier, ops_done;
  logic [31:0] mult_product, out_product;

  int          total = 0;
  int          bad   = 0;
  logic        model_err;
  logic [15:0] model_ops;

  mult_operand_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mult_start(mult_start),
    .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
    .mult_done(mult_done), .mult_product(mult_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .timeout_err(timeout_err), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction: wait_n = WAIT cycle carrying done (0 = never), hold = out_ready-low cycles
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int wait_n, input int hold);
    logic [31:0] exp;
    int          limit;
    bit          byp;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
    byp = BYPASS && (a == 16'h0000 || b == 16'h0000);
    if (byp) begin
      exp = 32'h0000_0000;
      chk("byp_no_start", {31'd0, mult_start}, 32'd0);
    end else begin
      chk("issue_start", {31'd0, mult_start}, 32'd1);
      chk("issue_busy", {31'd0, busy}, 32'd1);
      chk("issue_mcand", {16'd0, mult_multiplicand}, {16'd0, a});
      chk("issue_mplier", {16'd0, mult_multiplier}, {16'd0, b});
      limit = (wait_n == 0 || wait_n > TO) ? TO : wait_n;
      for (int k = 1; k <= limit; k++) begin
        @(negedge clk);
        chk("wait_no_valid", {31'd0, out_valid}, 32'd0);
        chk("wait_no_start", {31'd0, mult_start}, 32'd0);
        chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
        chk("wait_mcand", {16'd0, mult_multiplicand}, {16'd0, a});
        chk("wait_mplier", {16'd0, mult_multiplier}, {16'd0, b});
        chk("wait_err", {31'd0, timeout_err}, {31'd0, model_err});
        mult_done = (k == wait_n);
        mult_product = mult_done ? 32'(a) * 32'(b) : 32'($urandom);
      end
      @(negedge clk);
      mult_done = 1'b0;
      if (wait_n >= 1 && wait_n <= TO) begin
        exp = 32'(a) * 32'(b);
      end else begin
        exp = 32'hFFFF_FFFF;
        model_err = 1'b1;
      end
    end
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_product", out_product, exp);
    chk("out_err", {31'd0, timeout_err}, {31'd0, model_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_product", out_product, exp);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_ops = model_ops + 16'd1;
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_ops", {16'd0, ops_done}, {16'd0, model_ops});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
    mult_done = 1'b0; mult_product = 32'h0; out_ready = 1'b0;
    model_err = 1'b0; model_ops = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_start", {31'd0, mult_start}, 32'd0);
    chk("rst_mcand", {16'd0, mult_multiplicand}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", out_product, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops", {16'd0, ops_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(16'h0008, 16'h0010, 17, 0);
    run_op(16'hFFFF, 16'hFFFF, int'($urandom_range(1, 10)), 5);
    for (int i = 0; i < 6; i++)
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
    run_op(16'h0000, 16'h1234, 5, 1);
    run_op(16'h00AB, 16'h0000, 3, 0);

    // Timeout, then done on the very last allowed WAIT cycle, then a plain op
    run_op(16'h1111, 16'h2222, 0, 0);
    run_op(16'h0003, 16'h0005, TO, 0);
    run_op(16'h0007, 16'h0009, 2, 0);

    // Stray done while idle is ignored
    mult_done = 1'b1; mult_product = 32'($urandom);
    @(negedge clk);
    mult_done = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_valid", {31'd0, out_valid}, 32'd0);
    chk("stray_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of WAIT abandons the pair
    in_valid = 1'b1; in_a = 16'h0042; in_b = 16'h0101;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    model_err = 1'b0; model_ops = 16'h0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_mcand", {16'd0, mult_multiplicand}, 32'd0);
    chk("mrst_mplier", {16'd0, mult_multiplier}, 32'd0);
    chk("mrst_err", {31'd0, timeout_err}, 32'd0);
    chk("mrst_ops", {16'd0, ops_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0; mult_done = 1'b1; mult_product = 32'h0000_4242;
    @(negedge clk);
    mult_done = 1'b0;
    chk("late_done_valid", {31'd0, out_valid}, 32'd0);
    chk("late_done_busy", {31'd0, busy}, 32'd0);
    run_op(16'h0012, 16'h0034, 4, 0);

    // Counter wrap from a preloaded 16'hFFFF
    force dut.ops_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done_q;
    @(negedge clk);
    model_ops = 16'hFFFF;
    chk("preload_ops", {16'd0, ops_done}, 32'h0000_FFFF);
    run_op(16'h0002, 16'h0003, 1, 0);
    chk("wrap_ops", {16'd0, ops_done}, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
